serial_frame_ctrl: RTL

Frame sequencer for the radio module's single-wire serial output. It turns the serializer into a framed stream. Each frame is a sync word, then an 8-bit frame counter, then a fixed number of 8-bit sample words in the format {R0_I, R0_Q, R1_I, R1_Q}. The block owns the bit counter, sample latch timing, SYNC marker and frame-active flag. It sits between the radio sample inputs and DATA_OUT/SYNC/MISC, and runs entirely in the SYS_CLK domain.

---
 rtl/serial_frame_pkg.sv | 19 +
 rtl/frame_shift_reg.sv | 28 ++
 rtl/serial_frame_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/serial_frame_pkg.sv
// rtl/serial_frame_pkg.sv - shared types and constants for the serial frame sequencer
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
    } state_e;

    localparam int         HEADER_SLOTS      = 2;
    localparam int         BITS_PER_SLOT     = 8;
    localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hA5;

    // Counter width for n distinct values, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_shift_reg.sv
// rtl/frame_shift_reg.sv - 8-bit parallel-load MSB-first shifter with registered serial output
module frame_shift_reg (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       clr_i,
    input  logic       load_i,
    input  logic       shift_i,
    input  logic [7:0] data_i,
    output logic       serial_o
);

    logic [7:0] sr_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sr_q <= '0;
        end else if (clr_i) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= data_i;
        end else if (shift_i) begin
            sr_q <= {sr_q[6:0], 1'b0};
        end
    end

    assign serial_o = sr_q[7];

endmodule

// File: rtl/serial_frame_ctrl.sv
// rtl/serial_frame_ctrl.sv - frames radio samples into sync/counter/sample bytes on one serial wire
module serial_frame_ctrl
    import serial_frame_pkg::*;
#(
    parameter int         FRAME_SAMPLES = 256,
    parameter logic [7:0] SYNC_WORD     = DEFAULT_SYNC_WORD
) (
    input  logic       sys_clk_i,
    input  logic       rst_n_i,
    input  logic       en_i,
    input  logic [7:0] sample_i,
    output logic       data_out_o,
    output logic       sync_o,
    output logic       misc_o,
    output logic       sample_strobe_o,
    output logic [7:0] frame_cnt_o
);

    localparam int SC_W = cnt_width(FRAME_SAMPLES);
    localparam int BC_W = cnt_width(BITS_PER_SLOT);
    localparam int HS_W = cnt_width(HEADER_SLOTS);

    localparam logic [SC_W-1:0] LAST_SAMPLE = SC_W'(FRAME_SAMPLES - 1);
    localparam logic [BC_W-1:0] LAST_BIT    = BC_W'(BITS_PER_SLOT - 1);
    localparam logic [HS_W-1:0] LAST_HDR    = HS_W'(HEADER_SLOTS - 1);

    state_e            state_q;
    logic [BC_W-1:0]   bit_cnt_q;
    logic [HS_W-1:0]   hdr_slot_q;
    logic [SC_W-1:0]   sample_cnt_q;
    logic [7:0]        frame_cnt_q;
    logic              sync_q;
    logic              misc_q;
    logic              strobe_q;

    logic              slot_end;
    logic              last_sample;
    logic              sr_load;
    logic              sr_shift;
    logic              sr_clr;
    logic [7:0]        sr_data;

    assign slot_end    = (bit_cnt_q == LAST_BIT);
    assign last_sample = (sample_cnt_q == LAST_SAMPLE);

    // Shifter is loaded on the edge that opens each byte slot and shifted on every other edge.
    always_comb begin
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        sr_clr   = 1'b0;
        sr_data  = SYNC_WORD;
        unique case (state_q)
            IDLE: begin
                if (en_i) sr_load = 1'b1;
                else      sr_clr  = 1'b1;
            end
            HEADER: begin
                if (slot_end) begin
                    sr_load = 1'b1;
                    sr_data = (hdr_slot_q == LAST_HDR) ? sample_i : frame_cnt_q;
                end else begin
                    sr_shift = 1'b1;
                end
            end
            DATA: begin
                if (!slot_end) begin
                    sr_shift = 1'b1;
                end else if (!last_sample) begin
                    sr_load = 1'b1;
                    sr_data = sample_i;
                end else if (en_i) begin
                    sr_load = 1'b1;
                end else begin
                    sr_clr = 1'b1;
                end
            end
            default: sr_clr = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            hdr_slot_q   <= '0;
            sample_cnt_q <= '0;
            frame_cnt_q  <= '0;
            sync_q       <= 1'b0;
            misc_q       <= 1'b0;
            strobe_q     <= 1'b0;
        end else begin
            sync_q   <= 1'b0;
            strobe_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    bit_cnt_q <= '0;
                    if (en_i) begin
                        state_q    <= HEADER;
                        hdr_slot_q <= '0;
                        sync_q     <= 1'b1;
                        misc_q     <= 1'b1;
                    end else begin
                        misc_q <= 1'b0;
                    end
                end
                HEADER: begin
                    bit_cnt_q <= slot_end ? '0 : bit_cnt_q + BC_W'(1);
                    if (slot_end) begin
                        if (hdr_slot_q == LAST_HDR) begin
                            state_q      <= DATA;
                            sample_cnt_q <= '0;
                            strobe_q     <= 1'b1;
                        end else begin
                            hdr_slot_q <= hdr_slot_q + HS_W'(1);
                        end
                    end
                end
                DATA: begin
                    bit_cnt_q <= slot_end ? '0 : bit_cnt_q + BC_W'(1);
                    if (slot_end) begin
                        if (!last_sample) begin
                            sample_cnt_q <= sample_cnt_q + SC_W'(1);
                            strobe_q     <= 1'b1;
                        end else if (en_i) begin
                            // Back-to-back frame: counter advances as the new header starts.
                            state_q     <= HEADER;
                            hdr_slot_q  <= '0;
                            sync_q      <= 1'b1;
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                        end else begin
                            state_q <= IDLE;
                            misc_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    misc_q  <= 1'b0;
                end
            endcase
        end
    end

    frame_shift_reg u_shift (
        .clk_i    (sys_clk_i),
        .rst_n_i  (rst_n_i),
        .clr_i    (sr_clr),
        .load_i   (sr_load),
        .shift_i  (sr_shift),
        .data_i   (sr_data),
        .serial_o (data_out_o)
    );

    assign sync_o          = sync_q;
    assign misc_o          = misc_q;
    assign sample_strobe_o = strobe_q;
    assign frame_cnt_o     = frame_cnt_q;

endmodule
